mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, byte-address width of requests and RAM ports.
REQ-002 Parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 i_clk  in  1  single clock; all state on its rising edge.
REQ-004 i_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 i_req_valid  in  1  request valid.
REQ-006 o_req_ready  out  1  request ready.
REQ-007 i_req_we  in  1  1 = store, 0 = load.
REQ-008 i_req_funct3  in  3  RISC-V width/sign code.
REQ-009 i_req_addr  in  ADDR_WIDTH  byte address.
REQ-010 i_req_wdata  in  32  store data, right-justified.
REQ-011 o_rsp_valid / i_rsp_ready  out / in  1 / 1  response handshake.
REQ-012 o_rsp_rdata  out  32  load result, extended; 0 for stores.
REQ-013 o_rsp_err  out  1  illegal funct3.
REQ-014 o_ram_rd_addr, o_ram_rd_en, o_ram_rd_mask[3:0]  out  ADDR_WIDTH/1/4  RAM read port; RAM ignores addr[1:0].
REQ-015 i_ram_rd_data  in  32  combinational RAM read data, masked, bytes in lane position.
REQ-016 o_ram_wr_addr, o_ram_wr_en, o_ram_wr_mask[3:0], o_ram_wr_data[31:0]  out  RAM write port; write commits at the clock edge ending the cycle it is driven.

Function
REQ-017 States: IDLE, ACC0, ACC1, RESP; o_req_ready = 1 only in IDLE.
REQ-018 IDLE: on i_req_valid & o_req_ready, latch we/funct3/addr/wdata and go to ACC0, or to RESP with err=1 if funct3 is illegal.
REQ-019 Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; legal stores: 000 SB, 001 SH, 010 SW; all others illegal, with no RAM enable ever asserted.
REQ-020 Size s = 1/2/4 bytes; offset o = addr[1:0]; access is split when o+s > 4.
REQ-021 ACC0: drive word addr = {addr[AW-1:2],2'b00}, mask = lanes o..min(o+s-1,3); loads set rd_en and capture i_ram_rd_data; stores set wr_en with data = wdata << 8*o.
REQ-022 ACC0 goes to ACC1 if split, else RESP.
REQ-023 ACC1: address = ACC0 address + 4, wrapping modulo 2^ADDR_WIDTH; mask = lanes 0..o+s-5; store data = wdata >> 8*(4-o); load data captured; then RESP.
REQ-024 Load assembly: raw = (w0 >> 8*o) | (w1 << 8*(4-o)); truncate to s bytes; sign-extend for LB/LH, zero-extend for LBU/LHU/LW.
REQ-025 RAM enables and masks are 0 in IDLE and RESP, and read and write are never enabled in the same cycle.
REQ-026 RESP: o_rsp_valid = 1, rdata/err held stable until i_rsp_ready; then IDLE, with o_req_ready = 1 the next cycle.
REQ-027 Latency, from the acceptance edge to o_rsp_valid: aligned 2 cycles, split 3 cycles, illegal 1 cycle.
REQ-028 Store response: rdata = 0, err = 0.

Reset
REQ-029 On reset assertion, immediately: state IDLE, o_req_ready = 1 after release, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, all RAM enables/masks/addr/data = 0.
REQ-030 Reset during ACC1 of a split store leaves the ACC0 word written; no rollback.

Verification (RAM 0x00 = 0x44332211, 0x04 = 0x88776655)
REQ-031 LW 0x00 -> one read, mask 1111; rdata 0x44332211 two cycles after acceptance; err 0.
REQ-032 LB 0x07 -> 0xFFFFFF88; LBU 0x07 -> 0x00000088; LH 0x04 -> 0x00006655.
REQ-033 LW 0x02 -> reads at 0x00 mask 1100 then at 0x04 mask 0011; rdata 0x66554433 three cycles after acceptance.
REQ-034 SH 0x03, wdata 0x0000BEEF -> writes mask 1000/data 0xEF000000 @0x00, then mask 0001/data 0x000000BE @0x04; words become 0xEF332211 and 0x887766BE.
REQ-035 funct3 011 -> err 1, rdata 0, no rd_en/wr_en; i_rsp_ready held low for 5 cycles -> response held stable and o_req_ready = 0 throughout.
REQ-036 LW 0xFE (split) -> second read at 0x00 (wrap); separately, reset asserted in ACC1 -> all outputs 0 asynchronously, IDLE after release.

Source files
------------

// File: rtl/mem_lsu.sv
// Load/store unit: RISC-V byte/half/word accesses to a 32-bit word RAM.
// An access that crosses a word boundary is split into two RAM beats.
module mem_lsu #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    output logic                  o_ram_rd_en,
    output logic [3:0]            o_ram_rd_mask,
    input  logic [DATA_WIDTH-1:0] i_ram_rd_data,
    output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
    output logic                  o_ram_wr_en,
    output logic [3:0]            o_ram_wr_mask,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data
);
    localparam int unsigned LANES = 4;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] w0_q, w0_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic [3:0]            rd_mask_q, rd_mask_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_en_q, wr_en_d;
    logic [3:0]            wr_mask_q, wr_mask_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

    logic                  cur_we;
    logic [2:0]            cur_funct3;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [1:0]            off;
    logic [3:0]            size_mask;
    logic [7:0]            lane_mask8;
    logic                  split;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] word_addr0, word_addr1;
    logic [4:0]            sh_lo;
    logic [5:0]            sh_hi;
    logic [DATA_WIDTH-1:0] w0_c, w1_c, raw, load_val, rsp_data_c;

    // Decode the request being accepted (IDLE) or the one in flight.
    always_comb begin
        cur_we     = (state_q == IDLE) ? i_req_we     : we_q;
        cur_funct3 = (state_q == IDLE) ? i_req_funct3 : funct3_q;
        cur_addr   = (state_q == IDLE) ? i_req_addr   : addr_q;
        cur_wdata  = (state_q == IDLE) ? i_req_wdata  : wdata_q;
        off        = cur_addr[1:0];

        case (cur_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        // Upper nibble holds the lanes that spill into the next word.
        lane_mask8 = {4'b0000, size_mask} << off;
        split      = |lane_mask8[7:4];

        if (cur_we)
            legal = cur_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            legal = cur_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        word_addr0 = {cur_addr[ADDR_WIDTH-1:2], 2'b00};
        word_addr1 = word_addr0 + ADDR_WIDTH'(LANES);
        sh_lo      = {off, 3'b000};
        sh_hi      = 6'd32 - {1'b0, sh_lo};
    end

    // Load assembly from the two captured words, then width/sign extension.
    always_comb begin
        w0_c = (state_q == ACC0) ? i_ram_rd_data : w0_q;
        w1_c = (state_q == ACC1) ? i_ram_rd_data : '0;
        raw  = (w0_c >> sh_lo) | (w1_c << sh_hi);
        case (cur_funct3[1:0])
            2'b00:   load_val = cur_funct3[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   load_val = cur_funct3[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: load_val = raw;
        endcase
        rsp_data_c = cur_we ? '0 : load_val;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        w0_d        = w0_q;
        req_ready_d = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rd_addr_d   = '0;
        rd_en_d     = 1'b0;
        rd_mask_d   = 4'b0000;
        wr_addr_d   = '0;
        wr_en_d     = 1'b0;
        wr_mask_d   = 4'b0000;
        wr_data_d   = '0;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (i_req_valid && req_ready_q) begin
                    we_d        = i_req_we;
                    funct3_d    = i_req_funct3;
                    addr_d      = i_req_addr;
                    wdata_d     = i_req_wdata;
                    req_ready_d = 1'b0;
                    if (!legal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d = ACC0;
                        if (cur_we) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = word_addr0;
                            wr_mask_d = lane_mask8[3:0];
                            wr_data_d = cur_wdata << sh_lo;
                        end else begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = word_addr0;
                            rd_mask_d = lane_mask8[3:0];
                        end
                    end
                end
            end
            ACC0: begin
                w0_d = i_ram_rd_data;
                if (split) begin
                    state_d = ACC1;
                    if (cur_we) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = word_addr1;
                        wr_mask_d = lane_mask8[7:4];
                        wr_data_d = cur_wdata >> sh_hi;
                    end else begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = word_addr1;
                        rd_mask_d = lane_mask8[7:4];
                    end
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = rsp_data_c;
                end
            end
            ACC1: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_rdata_d = rsp_data_c;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            w0_q        <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rd_addr_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_mask_q   <= 4'b0000;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            wr_mask_q   <= 4'b0000;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            w0_q        <= w0_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rd_addr_q   <= rd_addr_d;
            rd_en_q     <= rd_en_d;
            rd_mask_q   <= rd_mask_d;
            wr_addr_q   <= wr_addr_d;
            wr_en_q     <= wr_en_d;
            wr_mask_q   <= wr_mask_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign o_req_ready   = req_ready_q;
    assign o_rsp_valid   = rsp_valid_q;
    assign o_rsp_rdata   = rsp_rdata_q;
    assign o_rsp_err     = rsp_err_q;
    assign o_ram_rd_addr = rd_addr_q;
    assign o_ram_rd_en   = rd_en_q;
    assign o_ram_rd_mask = rd_mask_q;
    assign o_ram_wr_addr = wr_addr_q;
    assign o_ram_wr_en   = wr_en_q;
    assign o_ram_wr_mask = wr_mask_q;
    assign o_ram_wr_data = wr_data_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed loads/stores against a small word RAM model.
module tb_mem_lsu;
    localparam int unsigned AW = 8;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_req_valid;
    logic          o_req_ready;
    logic          i_req_we;
    logic [2:0]    i_req_funct3;
    logic [AW-1:0] i_req_addr;
    logic [31:0]   i_req_wdata;
    logic          o_rsp_valid;
    logic          i_rsp_ready;
    logic [31:0]   o_rsp_rdata;
    logic          o_rsp_err;
    logic [AW-1:0] o_ram_rd_addr;
    logic          o_ram_rd_en;
    logic [3:0]    o_ram_rd_mask;
    logic [31:0]   i_ram_rd_data;
    logic [AW-1:0] o_ram_wr_addr;
    logic          o_ram_wr_en;
    logic [3:0]    o_ram_wr_mask;
    logic [31:0]   o_ram_wr_data;

    mem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_ram_rd_addr(o_ram_rd_addr), .o_ram_rd_en(o_ram_rd_en),
        .o_ram_rd_mask(o_ram_rd_mask), .i_ram_rd_data(i_ram_rd_data),
        .o_ram_wr_addr(o_ram_wr_addr), .o_ram_wr_en(o_ram_wr_en),
        .o_ram_wr_mask(o_ram_wr_mask), .o_ram_wr_data(o_ram_wr_data)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [7:0]  addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } ram_op_t;

    exp_t        exp_q[$];
    ram_op_t     rd_log[$];
    ram_op_t     wr_log[$];
    logic [31:0] mem [64];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cycle = 0;
    logic        tracking = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cycle <= cycle + 1;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // Word RAM: masked combinational read, byte-masked write on the clock edge.
    assign i_ram_rd_data = o_ram_rd_en ? (mem[o_ram_rd_addr[7:2]] & lane_bits(o_ram_rd_mask)) : 32'h0;

    always @(posedge i_clk) begin
        if (o_ram_wr_en) begin
            for (int b = 0; b < 4; b++)
                if (o_ram_wr_mask[b]) mem[o_ram_wr_addr[7:2]][8*b +: 8] <= o_ram_wr_data[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (o_ram_rd_en) rd_log.push_back('{o_ram_rd_addr, o_ram_rd_mask, 32'h0});
        if (o_ram_wr_en) wr_log.push_back('{o_ram_wr_addr, o_ram_wr_mask, o_ram_wr_data});
        if (o_ram_rd_en || o_ram_wr_en) check("rd_wr_exclusive", {31'd0, o_ram_rd_en & o_ram_wr_en}, 32'd0);
    end

    // Monitor: compares every presented response cycle against the queue head.
    always @(negedge i_clk) begin
        if (i_rst_n && o_rsp_valid) begin
            check("ready_low_while_rsp", {31'd0, o_req_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata 0x%08h with nothing expected", o_rsp_rdata);
            end else begin
                if (!tracking) begin
                    tracking = 1'b1;
                    check("latency", 32'(cycle - exp_q[0].acc + 1), 32'(exp_q[0].lat));
                end
                check("rsp_rdata", o_rsp_rdata, exp_q[0].rdata);
                check("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_q[0].err});
                if (i_rsp_ready) begin
                    void'(exp_q.pop_front());
                    tracking = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat);
        int   n;
        exp_t e;
        rd_log.delete();
        wr_log.delete();
        @(posedge i_clk);
        #1;
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = addr;
        i_req_wdata  = wdata;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (!o_req_ready) begin
            check("accept_timeout", {31'd0, o_req_ready}, 32'd1);
            i_req_valid = 1'b0;
            return;
        end
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = lat;
        e.acc   = cycle + 1;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("rsp_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            tracking = 1'b0;
        end
    endtask

    task automatic check_rd(input int n, input logic [7:0] a0, input logic [3:0] m0,
                            input logic [7:0] a1, input logic [3:0] m1);
        check("rd_count", 32'(rd_log.size()), 32'(n));
        if (n >= 1 && rd_log.size() >= 1) begin
            check("rd0_addr", {24'd0, rd_log[0].addr}, {24'd0, a0});
            check("rd0_mask", {28'd0, rd_log[0].mask}, {28'd0, m0});
        end
        if (n >= 2 && rd_log.size() >= 2) begin
            check("rd1_addr", {24'd0, rd_log[1].addr}, {24'd0, a1});
            check("rd1_mask", {28'd0, rd_log[1].mask}, {28'd0, m1});
        end
    endtask

    task automatic check_wr(input int n, input logic [7:0] a0, input logic [3:0] m0, input logic [31:0] d0,
                            input logic [7:0] a1, input logic [3:0] m1, input logic [31:0] d1);
        check("wr_count", 32'(wr_log.size()), 32'(n));
        if (n >= 1 && wr_log.size() >= 1) begin
            check("wr0_addr", {24'd0, wr_log[0].addr}, {24'd0, a0});
            check("wr0_mask", {28'd0, wr_log[0].mask}, {28'd0, m0});
            check("wr0_data", wr_log[0].data, d0);
        end
        if (n >= 2 && wr_log.size() >= 2) begin
            check("wr1_addr", {24'd0, wr_log[1].addr}, {24'd0, a1});
            check("wr1_mask", {28'd0, wr_log[1].mask}, {28'd0, m1});
            check("wr1_data", wr_log[1].data, d1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, {31'd0, o_req_ready}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, o_rsp_valid}, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, o_rsp_err}, 32'd0);
        check({tag, "_rsp_rdata"}, o_rsp_rdata, 32'd0);
        check({tag, "_rd_port"}, {19'd0, o_ram_rd_addr, o_ram_rd_en, o_ram_rd_mask}, 32'd0);
        check({tag, "_wr_ctl"}, {19'd0, o_ram_wr_addr, o_ram_wr_en, o_ram_wr_mask}, 32'd0);
        check({tag, "_wr_data"}, o_ram_wr_data, 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!o_req_ready && n < 5) begin
            @(negedge i_clk);
            n++;
        end
        check(tag, {31'd0, o_req_ready}, 32'd1);
    endtask

    initial begin
        int n;
        i_rst_n      = 1'b1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr   = 8'h00;
        i_req_wdata  = 32'h0;
        i_rsp_ready  = 1'b1;
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0]  <= 32'h44332211;
        mem[1]  <= 32'h88776655;
        mem[2]  <= 32'h000000F1;
        mem[63] <= 32'hDDCCBBAA;
        #1 i_rst_n = 1'b0;
        #1 check_all_zero("por");
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        wait_ready("ready_after_por");

        // Loads: we, funct3, addr, wdata, expected rdata, err, latency
        issue(1'b0, 3'b010, 8'h00, 32'h0, 32'h44332211, 1'b0, 2); drain();
        check_rd(1, 8'h00, 4'b1111, 8'h00, 4'b0000); check_wr(0, 8'h0, 4'h0, 32'h0, 8'h0, 4'h0, 32'h0);
        issue(1'b0, 3'b000, 8'h07, 32'h0, 32'hFFFFFF88, 1'b0, 2); drain();
        check_rd(1, 8'h04, 4'b1000, 8'h00, 4'b0000);
        issue(1'b0, 3'b100, 8'h07, 32'h0, 32'h00000088, 1'b0, 2); drain();
        issue(1'b0, 3'b001, 8'h04, 32'h0, 32'h00006655, 1'b0, 2); drain();
        check_rd(1, 8'h04, 4'b0011, 8'h00, 4'b0000);
        issue(1'b0, 3'b010, 8'h02, 32'h0, 32'h66554433, 1'b0, 3); drain();
        check_rd(2, 8'h00, 4'b1100, 8'h04, 4'b0011);
        issue(1'b0, 3'b010, 8'hFE, 32'h0, 32'h2211DDCC, 1'b0, 3); drain();
        check_rd(2, 8'hFC, 4'b1100, 8'h00, 4'b0011);
        issue(1'b0, 3'b001, 8'h05, 32'h0, 32'h00007766, 1'b0, 2); drain();
        check_rd(1, 8'h04, 4'b0110, 8'h00, 4'b0000);
        issue(1'b0, 3'b001, 8'h07, 32'h0, 32'hFFFFF188, 1'b0, 3); drain();
        check_rd(2, 8'h04, 4'b1000, 8'h08, 4'b0001);
        issue(1'b0, 3'b101, 8'h07, 32'h0, 32'h0000F188, 1'b0, 3); drain();

        // Stores
        issue(1'b1, 3'b001, 8'h03, 32'h0000BEEF, 32'h0, 1'b0, 3); drain();
        check_wr(2, 8'h00, 4'b1000, 32'hEF000000, 8'h04, 4'b0001, 32'h000000BE);
        check_rd(0, 8'h00, 4'b0000, 8'h00, 4'b0000);
        check("mem0_after_sh", mem[0], 32'hEF332211);
        check("mem1_after_sh", mem[1], 32'h887766BE);
        issue(1'b1, 3'b000, 8'h09, 32'h123456AB, 32'h0, 1'b0, 2); drain();
        check_wr(1, 8'h08, 4'b0010, 32'h3456AB00, 8'h00, 4'b0000, 32'h0);
        issue(1'b0, 3'b010, 8'h08, 32'h0, 32'h0000ABF1, 1'b0, 2); drain();

        // Illegal codes, response back-pressured for 5 cycles
        @(posedge i_clk);
        #1 i_rsp_ready = 1'b0;
        issue(1'b0, 3'b011, 8'h00, 32'h0, 32'h0, 1'b1, 1);
        repeat (5) @(posedge i_clk);
        #1 i_rsp_ready = 1'b1;
        drain();
        check_rd(0, 8'h00, 4'b0000, 8'h00, 4'b0000); check_wr(0, 8'h0, 4'h0, 32'h0, 8'h0, 4'h0, 32'h0);
        issue(1'b1, 3'b100, 8'h04, 32'hFFFFFFFF, 32'h0, 1'b1, 1); drain();
        check_wr(0, 8'h0, 4'h0, 32'h0, 8'h0, 4'h0, 32'h0);
        check("mem1_untouched", mem[1], 32'h887766BE);

        // Reset asserted during the second beat of a split store
        @(posedge i_clk);
        #1;
        i_req_valid  = 1'b1;
        i_req_we     = 1'b1;
        i_req_funct3 = 3'b010;
        i_req_addr   = 8'h12;
        i_req_wdata  = 32'hAABBCCDD;
        n = 0;
        @(negedge i_clk);
        while (!o_req_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("split_store_accept", {31'd0, o_req_ready}, 32'd1);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(posedge i_clk);
        #2;
        check("acc1_wr_ctl", {19'd0, o_ram_wr_addr, o_ram_wr_en, o_ram_wr_mask}, {19'd0, 8'h14, 1'b1, 4'b0011});
        check("acc1_wr_data", o_ram_wr_data, 32'h0000AABB);
        i_rst_n = 1'b0;
        #1 check_all_zero("mid_rst");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        wait_ready("ready_after_mid_rst");
        check("rsp_idle_after_rst", {31'd0, o_rsp_valid}, 32'd0);
        check("mem4_acc0_kept", mem[4], 32'hCCDD0000);
        check("mem5_acc1_dropped", mem[5], 32'h00000000);
        issue(1'b0, 3'b010, 8'h10, 32'h0, 32'hCCDD0000, 1'b0, 2); drain();

        repeat (2) @(negedge i_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
